// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package csa_pkg;

    // Resolver FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_res_state_t;

    // Number of CHUNK-bit slices in the (w+2)-bit resolved result
    function automatic int nchunk(input int w, input int c);
        return (w + 2) / c;
    endfunction

    // Width of the chunk index counter; never narrower than one bit
    function automatic int idx_width(input int w, input int c);
        int n;
        n = nchunk(w, c);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default configuration
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_CHUNK  = 2;
    localparam int DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
    localparam int DEF_IDX_W  = idx_width(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/csa_chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full_adder cells.
module csa_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the chunk ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_resolver.sv
// Multi-cycle carry-save resolver: Result = Sum + 2*Carry, resolved CHUNK
// bits per cycle with valid/ready handshakes on both sides.
// Optional macro CSA_RESOLVER_BYPASS_EN: a pair with Carry==0 skips the
// ripple phase and goes straight to DONE with Result = {2'b00, Sum}.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Sum,
    input  logic [WIDTH-1:0] Carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] Result,
    output logic             busy
);

    localparam int RW     = WIDTH + 2;
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(WIDTH, CHUNK);

    // Reject configurations whose result width does not split evenly
    if (CHUNK < 1 || (RW % CHUNK) != 0) begin : g_chunk_check
        $error("csa_resolver: (WIDTH+2) must be a positive multiple of CHUNK");
    end

    csa_res_state_t  state;
    logic [IW-1:0]   idx;
    logic            cflag;
    logic [RW-1:0]   op_a;
    logic [RW-1:0]   op_b;

    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
    logic             last;
    logic             bypass;

    assign ch_a = op_a[int'(idx)*CHUNK +: CHUNK];
    assign ch_b = op_b[int'(idx)*CHUNK +: CHUNK];
    assign last = (idx == IW'(NCHUNK - 1));

`ifdef CSA_RESOLVER_BYPASS_EN
    assign bypass = (Carry == '0);
`else
    assign bypass = 1'b0;
`endif

    csa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .cin  (cflag),
        .s    (ch_s),
        .cout (ch_cout)
    );

    // Resolver FSM: capture, ripple one chunk per cycle, hold until drained
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cflag     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            Result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= {2'b00, Sum};
                        op_b     <= {1'b0, Carry, 1'b0};
                        idx      <= '0;
                        cflag    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (bypass) begin
                            // No carries to propagate: the sum vector is the answer
                            Result    <= {2'b00, Sum};
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    Result[int'(idx)*CHUNK +: CHUNK] <= ch_s;
                    cflag <= ch_cout;
                    if (last) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Operands fit in WIDTH+2 bits, so the top chunk can never carry out
    a_final_carry_zero: assert property (
        @(posedge clk) disable iff (rst) (state == RUN && last) |-> !ch_cout
    );

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: default instance plus two parameter
// variants (WIDTH=4/CHUNK=3 and WIDTH=14/CHUNK=4).
module tb_csa_resolver;

`ifdef CSA_RESOLVER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] sum, carry;
    logic [9:0] result;

    // WIDTH=4, CHUNK=3 instance
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [3:0] a_sum, a_carry;
    logic [5:0] a_result;

    // WIDTH=14, CHUNK=4 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [13:0] b_sum, b_carry;
    logic [15:0] b_result;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] sb[$];

    csa_resolver #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Sum(sum), .Carry(carry), .out_valid(out_valid), .out_ready(out_ready),
        .Result(result), .busy(busy)
    );

    csa_resolver #(.WIDTH(4), .CHUNK(3)) dut_w4 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .Sum(a_sum), .Carry(a_carry), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .Result(a_result), .busy(a_busy)
    );

    csa_resolver #(.WIDTH(14), .CHUNK(4)) dut_w14 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Sum(b_sum), .Carry(b_carry), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .Result(b_result), .busy(b_busy)
    );

    // Cycles from the accepting edge until out_valid is visible
    function automatic int exp_lat(input logic zero_carry, input int n);
        if (BYP && zero_carry) return 0;
        return n;
    endfunction

    // Drive one pair into the default instance and record its expected result
    task automatic accept_pair(input logic [7:0] s, input logic [7:0] c, input logic [15:0] e);
        @(negedge clk);
        sum      = s;
        carry    = c;
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (result !== 10'h000) begin n_fail++; $display("FAIL reset_result: got %h expected 000", result); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w4: busy %b in_ready %b expected 0/1", a_busy, a_in_ready); end
        n_chk++; if (b_busy !== 1'b0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w14: busy %b in_ready %b expected 0/1", b_busy, b_in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_max_operands;
        int first, vcnt, lo;
        logic [15:0] e;
        first = -1; vcnt = 0; lo = 0;
        out_ready = 1'b1;
        accept_pair(8'hFF, 8'hFF, 16'h02FD);
        for (int k = 0; k < 12; k++) begin
            if (!in_ready) lo++;
            if (out_valid) begin
                if (first < 0) first = k;
                vcnt++;
                if (sb.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL max_extra_output: result %h with empty scoreboard", result);
                end else begin
                    e = sb.pop_front();
                    n_chk++; if ({6'd0, result} !== e) begin n_fail++; $display("FAIL max_result: got %h expected %h", result, e); end
                end
            end
            @(negedge clk);
        end
        n_chk++; if (first !== 5) begin n_fail++; $display("FAIL max_latency: got %0d expected 5", first); end
        n_chk++; if (vcnt !== 1) begin n_fail++; $display("FAIL max_valid_width: got %0d cycles expected 1", vcnt); end
        n_chk++; if (lo !== 6) begin n_fail++; $display("FAIL max_in_ready_low: got %0d cycles expected 6", lo); end
    endtask

    task automatic test_no_carry;
        int first;
        logic [15:0] e;
        first = -1;
        out_ready = 1'b1;
        accept_pair(8'h5A, 8'h00, 16'h005A);
        for (int k = 0; k < 12 && first < 0; k++) begin
            if (out_valid) begin
                first = k;
                e = sb.pop_front();
                n_chk++; if ({6'd0, result} !== e) begin n_fail++; $display("FAIL nocarry_result: got %h expected %h", result, e); end
            end
            @(negedge clk);
        end
        n_chk++; if (first !== exp_lat(1'b1, 5)) begin n_fail++; $display("FAIL nocarry_latency: got %0d expected %0d", first, exp_lat(1'b1, 5)); end
    endtask

    task automatic test_stall;
        int k;
        logic [15:0] e;
        out_ready = 1'b0;
        accept_pair(8'h33, 8'h11, 16'h0055);
        for (k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        n_chk++; if (!out_valid) begin n_fail++; $display("FAIL stall_timeout: out_valid %b after %0d cycles expected 1", out_valid, k); end
        // A competing pair must be ignored while the result is held
        sum = 8'h77; carry = 8'h01; in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_chk++; if (result !== 10'h055) begin n_fail++; $display("FAIL stall_result: cycle %0d got %h expected 055", j, result); end
            n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_handshake: cycle %0d out_valid %b in_ready %b expected 1/0", j, out_valid, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        n_chk++; if ({6'd0, result} !== e) begin n_fail++; $display("FAIL stall_release_result: got %h expected %h", result, e); end
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: out_valid %b in_ready %b busy %b expected 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_abort;
        int first;
        logic [15:0] e;
        out_ready = 1'b1;
        @(negedge clk);
        sum = 8'hAA; carry = 8'h55; in_valid = 1'b1;
        sb.push_back(16'h0154);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (result !== 10'h000) begin n_fail++; $display("FAIL abort_result: got %h expected 000", result); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        accept_pair(8'h01, 8'h01, 16'h0003);
        first = -1;
        for (int k = 0; k < 12 && first < 0; k++) begin
            if (out_valid) begin
                first = k;
                e = sb.pop_front();
                n_chk++; if ({6'd0, result} !== e) begin n_fail++; $display("FAIL abort_next_result: got %h expected %h", result, e); end
            end
            @(negedge clk);
        end
        n_chk++; if (first !== 5) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 5", first); end
    endtask

    task automatic test_back_to_back;
        int acc, got;
        bit pend;
        logic [15:0] e;
        acc = 0; got = 0; pend = 0;
        @(negedge clk);
        sum = 8'($urandom); carry = 8'($urandom); in_valid = 1'b1;
        for (int cyc = 0; cyc < 20000 && (acc < 1000 || sb.size() != 0); cyc++) begin
            if (pend) begin
                sum = 8'($urandom); carry = 8'($urandom); pend = 0;
                if (acc == 1000) in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL b2b_extra_output: result %h with empty scoreboard", result);
                end else begin
                    e = sb.pop_front();
                    got++;
                    n_chk++; if ({6'd0, result} !== e) begin n_fail++; $display("FAIL b2b_result: output %0d got %h expected %h", got, result, e); end
                end
            end
            if (in_valid && in_ready) begin
                n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_busy: busy %b expected 0", busy); end
                sb.push_back({8'd0, sum} + {7'd0, carry, 1'b0});
                acc++;
                pend = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_chk++; if (got !== 1000) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 1000", got); end
        sb.delete();
    endtask

    task automatic test_sweep_w4;
        int lat;
        logic [15:0] e;
        a_out_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                a_sum = 4'(s); a_carry = 4'(c); a_in_valid = 1'b1;
                sb.push_back(16'(s) + 16'(2 * c));
                @(negedge clk);
                a_in_valid = 1'b0;
                for (lat = 0; lat < 20 && !a_out_valid; lat++) @(negedge clk);
                e = sb.pop_front();
                n_chk++; if ({10'd0, a_result} !== e) begin n_fail++; $display("FAIL w4_result: s=%0d c=%0d got %h expected %h", s, c, a_result, e); end
                n_chk++; if (lat !== exp_lat(c == 0, 2)) begin n_fail++; $display("FAIL w4_latency: s=%0d c=%0d got %0d expected %0d", s, c, lat, exp_lat(c == 0, 2)); end
            end
        end
    endtask

    task automatic test_sweep_w14;
        int lat;
        logic [13:0] s, c;
        logic [15:0] e;
        b_out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s = (i == 0) ? 14'h3FFF : 14'($urandom);
            c = (i == 0) ? 14'h3FFF : ((i == 1) ? 14'h0000 : 14'($urandom));
            @(negedge clk);
            b_sum = s; b_carry = c; b_in_valid = 1'b1;
            sb.push_back({2'b00, s} + {1'b0, c, 1'b0});
            @(negedge clk);
            b_in_valid = 1'b0;
            for (lat = 0; lat < 20 && !b_out_valid; lat++) @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (b_result !== e) begin n_fail++; $display("FAIL w14_result: s=%h c=%h got %h expected %h", s, c, b_result, e); end
            n_chk++; if (lat !== exp_lat(c == 0, 4)) begin n_fail++; $display("FAIL w14_latency: s=%h c=%h got %0d expected %0d", s, c, lat, exp_lat(c == 0, 4)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; sum = '0; carry = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_sum = '0; a_carry = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_sum = '0; b_carry = '0;
        test_reset();
        test_max_operands();
        test_no_carry();
        test_stall();
        test_abort();
        test_back_to_back();
        test_sweep_w4();
        test_sweep_w14();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global bound so a stuck handshake can never hang the run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
